// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared VGA / text-overlay definitions: character cell geometry, text box size,
// default overlay colours and packed bundles for the timing+pixel stream and
// the per-pixel cell information that travels alongside it.
// -----------------------------------------------------------------------------
package vga_pkg;

  localparam int CHAR_W   = 8;   // cell width in pixels
  localparam int CHAR_H   = 16;  // cell height in pixels (glyph lines)
  localparam int TXT_COLS = 16;  // text box width in cells
  localparam int TXT_ROWS = 16;  // text box height in cells

  localparam int BOX_W = CHAR_W * TXT_COLS;  // 128 px
  localparam int BOX_H = CHAR_H * TXT_ROWS;  // 256 px

  localparam logic [11:0] DEF_TEXT_COLOR   = 12'hFFF;
  localparam logic [11:0] DEF_HILITE_COLOR = 12'h00F;

  // Timing strobes, counters and background pixel: 38 bits.
  typedef struct packed {
    logic [10:0] vcount;
    logic [10:0] hcount;
    logic        vsync;
    logic        hsync;
    logic        vblnk;
    logic        hblnk;
    logic [11:0] rgb;
  } vga_t;

  // Per-pixel cell information needed at the compositing stage: 8 bits.
  typedef struct packed {
    logic       in_box;
    logic [3:0] row;
    logic [2:0] xoff;
  } cell_t;

endpackage

// File: rtl/delay.sv
// -----------------------------------------------------------------------------
// delay
// Generic fixed-latency delay line.
//   clk  : clock
//   rst  : synchronous, active-high reset (clears every stage)
//   din  : WIDTH-bit input
//   dout : din delayed by CLK_DEL clocks (CLK_DEL >= 1)
// -----------------------------------------------------------------------------
module delay #(
  parameter int WIDTH   = 8,
  parameter int CLK_DEL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [CLK_DEL];
  logic [WIDTH-1:0] stage_d [CLK_DEL];

  always_comb begin
    stage_d[0] = din;
    for (int i = 1; i < CLK_DEL; i++) stage_d[i] = stage_q[i-1];
  end

  // NOTE: these are plain pipeline flops, not a RAM, so clearing every stage
  // on reset is cheap and guarantees a clean stream after reset release.
  always_ff @(posedge clk) begin
    for (int i = 0; i < CLK_DEL; i++) begin
      if (rst) stage_q[i] <= '0;
      else     stage_q[i] <= stage_d[i];
    end
  end

  assign dout = stage_q[CLK_DEL-1];

endmodule

// File: rtl/draw_menu_char.sv
// -----------------------------------------------------------------------------
// draw_menu_char
// Text-overlay stage of the menu renderer. Addresses the external text ROM
// (char_xy) and font ROM ({char_code, char_line}), then overlays the returned
// glyph line onto the RGB stream, optionally highlighting one text row.
//   clk, rst                      : pixel clock, synchronous active-high reset
//   vcount_in/hcount_in, *sync_in,
//   *blnk_in, rgb_in              : incoming timing and background pixel
//   sel_row, hilite_en            : cursor row / enable, latched at frame start
//   char_xy  -> / char_code <-    : text ROM address {row,col} / data (1 clk)
//   char_line -> / char_pixels <- : glyph line / font ROM data (1 clk)
//   *_out                         : timing and composited pixel, 4 clk later
// -----------------------------------------------------------------------------
module draw_menu_char
  import vga_pkg::*;
#(
  parameter logic [10:0] X_POS        = 11'd64,
  parameter logic [10:0] Y_POS        = 11'd48,
  parameter logic [11:0] TEXT_COLOR   = DEF_TEXT_COLOR,
  parameter logic [11:0] HILITE_COLOR = DEF_HILITE_COLOR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] vcount_in,
  input  logic [10:0] hcount_in,
  input  logic        vsync_in,
  input  logic        hsync_in,
  input  logic        vblnk_in,
  input  logic        hblnk_in,
  input  logic [11:0] rgb_in,
  input  logic [3:0]  sel_row,
  input  logic        hilite_en,
  output logic [7:0]  char_xy,
  input  logic [6:0]  char_code,
  output logic [3:0]  char_line,
  input  logic [7:0]  char_pixels,
  output logic [10:0] vcount_out,
  output logic [10:0] hcount_out,
  output logic        vsync_out,
  output logic        hsync_out,
  output logic        vblnk_out,
  output logic        hblnk_out,
  output logic [11:0] rgb_out
);

  localparam logic [10:0] X_LAST = X_POS + 11'(BOX_W - 1);
  localparam logic [10:0] Y_LAST = Y_POS + 11'(BOX_H - 1);

  // ---------------------------------------------------------------- stage 0
  logic       in_box;
  logic [6:0] dx;  // only the bits that address a cell inside the box
  logic [7:0] dy;
  vga_t       vga_in;
  cell_t      cell_in;

  // Low bits of a difference depend only on the low bits of the operands.
  assign dx = hcount_in[6:0] - X_POS[6:0];
  assign dy = vcount_in[7:0] - Y_POS[7:0];

  assign in_box = (hcount_in >= X_POS) && (hcount_in <= X_LAST) &&
                  (vcount_in >= Y_POS) && (vcount_in <= Y_LAST) &&
                  !hblnk_in && !vblnk_in;

  assign vga_in  = '{vcount: vcount_in, hcount: hcount_in, vsync: vsync_in,
                     hsync: hsync_in, vblnk: vblnk_in, hblnk: hblnk_in,
                     rgb: rgb_in};
  assign cell_in = '{in_box: in_box, row: dy[7:4], xoff: dx[2:0]};

  // ------------------------------------------------ ROM addressing registers
  logic [7:0] char_xy_q,   char_xy_d;
  logic [3:0] line_s1_q,   line_s1_d;
  logic       in_box_s1_q, in_box_s1_d;
  logic [3:0] char_line_q, char_line_d;
  logic [3:0] sel_q,       sel_d;
  logic       hl_en_q,     hl_en_d;

  // NOTE: every signal gets its hold value as the default first, so no path
  // through this block can leave one unassigned and infer a latch.
  always_comb begin
    char_xy_d   = char_xy_q;
    char_line_d = char_line_q;
    sel_d       = sel_q;
    hl_en_d     = hl_en_q;
    line_s1_d   = dy[3:0];
    in_box_s1_d = in_box;
    if (in_box)      char_xy_d   = {dy[7:4], dx[6:3]};
    // char_line follows stage 1 so it lines up with char_code from the ROM.
    if (in_box_s1_q) char_line_d = line_s1_q;
    // Cursor is sampled once per frame so a mid-frame change cannot tear.
    if (vcount_in == 11'd0 && hcount_in == 11'd0) begin
      sel_d   = sel_row;
      hl_en_d = hilite_en;
    end
  end

  // NOTE: non-blocking assignments for all state so every flop samples the
  // pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      char_xy_q   <= '0;
      line_s1_q   <= '0;
      in_box_s1_q <= 1'b0;
      char_line_q <= '0;
      sel_q       <= '0;
      hl_en_q     <= 1'b0;
    end else begin
      char_xy_q   <= char_xy_d;
      line_s1_q   <= line_s1_d;
      in_box_s1_q <= in_box_s1_d;
      char_line_q <= char_line_d;
      sel_q       <= sel_d;
      hl_en_q     <= hl_en_d;
    end
  end

  assign char_xy   = char_xy_q;
  assign char_line = char_line_q;

  // ------------------------------------------- stages 1..3 (delay lines)
  vga_t  vga_s3;
  cell_t cell_s3;

  delay #(.WIDTH($bits(vga_t)), .CLK_DEL(3)) u_vga_delay (
    .clk  (clk),
    .rst  (rst),
    .din  (vga_in),
    .dout (vga_s3)
  );

  delay #(.WIDTH($bits(cell_t)), .CLK_DEL(3)) u_cell_delay (
    .clk  (clk),
    .rst  (rst),
    .din  (cell_in),
    .dout (cell_s3)
  );

  // ------------------------------------------------ stage 4 (compositing)
  vga_t vga_out_q, vga_out_d;
  logic pixel_on;

  // char_code is consumed by the external font ROM, not by this block.
  logic unused_code;
  assign unused_code = ^char_code;

  assign pixel_on = char_pixels[3'd7 - cell_s3.xoff];

  always_comb begin
    vga_out_d = vga_s3;
    if (cell_s3.in_box) begin
      if (pixel_on)                             vga_out_d.rgb = TEXT_COLOR;
      else if (hl_en_q && cell_s3.row == sel_q) vga_out_d.rgb = HILITE_COLOR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) vga_out_q <= '0;
    else     vga_out_q <= vga_out_d;
  end

  assign vcount_out = vga_out_q.vcount;
  assign hcount_out = vga_out_q.hcount;
  assign vsync_out  = vga_out_q.vsync;
  assign hsync_out  = vga_out_q.hsync;
  assign vblnk_out  = vga_out_q.vblnk;
  assign hblnk_out  = vga_out_q.hblnk;
  assign rgb_out    = vga_out_q.rgb;

endmodule

// File: tb/tb_draw_menu_char.sv
// -----------------------------------------------------------------------------
// tb_draw_menu_char
// Directed bench for draw_menu_char with registered text/font ROM models.
// -----------------------------------------------------------------------------
module tb_draw_menu_char;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] vcount_in, hcount_in;
  logic        vsync_in, hsync_in, vblnk_in, hblnk_in;
  logic [11:0] rgb_in;
  logic [3:0]  sel_row;
  logic        hilite_en;
  logic [7:0]  char_xy;
  logic [6:0]  char_code;
  logic [3:0]  char_line;
  logic [7:0]  char_pixels;
  logic [10:0] vcount_out, hcount_out;
  logic        vsync_out, hsync_out, vblnk_out, hblnk_out;
  logic [11:0] rgb_out;

  logic font_all_on;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  draw_menu_char dut (
    .clk(clk), .rst(rst),
    .vcount_in(vcount_in), .hcount_in(hcount_in),
    .vsync_in(vsync_in), .hsync_in(hsync_in),
    .vblnk_in(vblnk_in), .hblnk_in(hblnk_in),
    .rgb_in(rgb_in), .sel_row(sel_row), .hilite_en(hilite_en),
    .char_xy(char_xy), .char_code(char_code),
    .char_line(char_line), .char_pixels(char_pixels),
    .vcount_out(vcount_out), .hcount_out(hcount_out),
    .vsync_out(vsync_out), .hsync_out(hsync_out),
    .vblnk_out(vblnk_out), .hblnk_out(hblnk_out),
    .rgb_out(rgb_out)
  );

  // Text ROM: code = low 7 bits of the cell address. Font ROM: only glyph
  // 0x23 line 5 has a lit pixel (bit 5), unless font_all_on forces 8'hFF.
  always @(posedge clk) begin
    char_code <= char_xy[6:0];
    if (font_all_on)
      char_pixels <= 8'hFF;
    else if (char_code == 7'h23 && char_line == 4'd5)
      char_pixels <= 8'b0010_0000;
    else
      char_pixels <= 8'h00;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [10:0] h, input logic [10:0] v,
                       input logic [11:0] rgb, input logic hb);
    hcount_in = h;
    vcount_in = v;
    rgb_in    = rgb;
    hblnk_in  = hb;
  endtask

  // Presents one pixel, holds it, and checks the result at N+4. When chk_addr
  // is set, also checks char_xy at N+1 and char_line at N+2.
  task automatic run_pixel(input string tag, input logic [10:0] h,
                           input logic [10:0] v, input logic [11:0] rgb,
                           input logic hb, input logic [11:0] exp_rgb,
                           input logic chk_addr, input logic [7:0] exp_xy,
                           input logic [3:0] exp_line);
    drive(h, v, rgb, hb);
    tick();
    if (chk_addr) check({tag, ".xy"}, 32'(char_xy), 32'(exp_xy));
    tick();
    if (chk_addr) check({tag, ".line"}, 32'(char_line), 32'(exp_line));
    tick();
    tick();
    check({tag, ".rgb"}, 32'(rgb_out), 32'(exp_rgb));
    check({tag, ".hcnt"}, 32'(hcount_out), 32'(h));
    check({tag, ".vcnt"}, 32'(vcount_out), 32'(v));
  endtask

  task automatic frame_start(input logic [3:0] sel, input logic en);
    sel_row   = sel;
    hilite_en = en;
    drive(11'd0, 11'd0, 12'h000, 1'b0);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    font_all_on = 1'b0;
    vsync_in = 1'b0; hsync_in = 1'b0; vblnk_in = 1'b0;
    sel_row = 4'd0; hilite_en = 1'b0;
    drive(11'd10, 11'd3, 12'hABC, 1'b0);

    // Reset with a free-running counter.
    for (int i = 0; i < 3; i++) begin
      hcount_in = 11'(10 + i);
      tick();
    end
    check("rst.rgb", 32'(rgb_out), 32'h0);
    check("rst.hcnt", 32'(hcount_out), 32'h0);
    check("rst.xy", 32'(char_xy), 32'h0);
    check("rst.line", 32'(char_line), 32'h0);

    rst = 1'b0;
    vsync_in = 1'b1;
    for (int k = 0; k < 6; k++) begin
      hcount_in = 11'(20 + k);
      tick();
      if (k < 3) begin
        check($sformatf("rel%0d.rgb", k), 32'(rgb_out), 32'h0);
        check($sformatf("rel%0d.hcnt", k), 32'(hcount_out), 32'h0);
        check($sformatf("rel%0d.vs", k), 32'(vsync_out), 32'h0);
      end else begin
        check($sformatf("rel%0d.rgb", k), 32'(rgb_out), 32'hABC);
        check($sformatf("rel%0d.hcnt", k), 32'(hcount_out), 32'(20 + k - 3));
        check($sformatf("rel%0d.vcnt", k), 32'(vcount_out), 32'd3);
        check($sformatf("rel%0d.vs", k), 32'(vsync_out), 32'h1);
      end
    end
    vsync_in = 1'b0;

    // Glyph lookup: cell (2,3), line 5, xoff 2 lit; xoff 3 dark.
    run_pixel("glyph_x2", 11'd90, 11'd85, 12'h5A5, 1'b0, 12'hFFF,
              1'b1, 8'h23, 4'd5);
    run_pixel("glyph_x3", 11'd91, 11'd85, 12'h5A5, 1'b0, 12'h5A5,
              1'b1, 8'h23, 4'd5);

    // Highlight latched at frame start.
    frame_start(4'd2, 1'b1);
    run_pixel("hl_row2", 11'd74, 11'd81, 12'h123, 1'b0, 12'h00F,
              1'b1, 8'h21, 4'd1);
    run_pixel("hl_row3", 11'd74, 11'd96, 12'h123, 1'b0, 12'h123,
              1'b1, 8'h31, 4'd0);
    run_pixel("hl_glyph", 11'd90, 11'd85, 12'h123, 1'b0, 12'hFFF,
              1'b0, 8'h00, 4'd0);

    // Mid-frame cursor change has no effect until the next frame start.
    sel_row = 4'd5;
    run_pixel("mid_row2", 11'd74, 11'd81, 12'h123, 1'b0, 12'h00F,
              1'b0, 8'h00, 4'd0);
    run_pixel("mid_row5", 11'd74, 11'd128, 12'h123, 1'b0, 12'h123,
              1'b0, 8'h00, 4'd0);
    frame_start(4'd5, 1'b1);
    run_pixel("new_row5", 11'd74, 11'd128, 12'h123, 1'b0, 12'h00F,
              1'b0, 8'h00, 4'd0);
    run_pixel("new_row2", 11'd74, 11'd81, 12'h123, 1'b0, 12'h123,
              1'b0, 8'h00, 4'd0);

    // Box boundaries, with every font pixel lit to expose masking faults.
    font_all_on = 1'b1;
    run_pixel("last_cell", 11'd191, 11'd303, 12'h456, 1'b0, 12'hFFF,
              1'b1, 8'hFF, 4'd15);
    run_pixel("h63", 11'd63, 11'd85, 12'h456, 1'b0, 12'h456,
              1'b1, 8'hFF, 4'd15);
    run_pixel("h64", 11'd64, 11'd48, 12'h456, 1'b0, 12'hFFF,
              1'b1, 8'h00, 4'd0);
    run_pixel("h192", 11'd192, 11'd85, 12'h456, 1'b0, 12'h456,
              1'b1, 8'h00, 4'd0);
    run_pixel("v47", 11'd90, 11'd47, 12'h456, 1'b0, 12'h456,
              1'b0, 8'h00, 4'd0);
    run_pixel("v304", 11'd90, 11'd304, 12'h456, 1'b0, 12'h456,
              1'b0, 8'h00, 4'd0);
    run_pixel("hblnk", 11'd90, 11'd85, 12'h456, 1'b1, 12'h456,
              1'b0, 8'h00, 4'd0);
    check("hblnk.out", 32'(hblnk_out), 32'h1);
    font_all_on = 1'b0;

    // Mid-frame reset drops the highlight until the next frame start.
    rst = 1'b1;
    tick();
    check("rst2.rgb", 32'(rgb_out), 32'h0);
    rst = 1'b0;
    run_pixel("rst2_row5", 11'd74, 11'd128, 12'h321, 1'b0, 12'h321,
              1'b0, 8'h00, 4'd0);
    frame_start(4'd5, 1'b1);
    run_pixel("rst2_hl", 11'd74, 11'd128, 12'h321, 1'b0, 12'h00F,
              1'b0, 8'h00, 4'd0);
    frame_start(4'd5, 1'b0);
    run_pixel("hl_off", 11'd74, 11'd128, 12'h321, 1'b0, 12'h321,
              1'b0, 8'h00, 4'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/draw_menu_char.md
Name: draw_menu_char

Overview:
- Text-overlay stage of the menu renderer. Sits upstream and downstream of the menu text ROM.
- From the VGA timing counters it computes the 8-bit character cell address {row[3:0], col[3:0]} that the text ROM takes. It then receives the 7-bit char_code the ROM returns and forms the font ROM line address.
- It takes the 8-pixel glyph line from the font ROM and overlays the glyph onto the incoming RGB stream.
- It can highlight one text row, used as the menu cursor. The highlight is latched per frame.

Parameters:
- X_POS, 11'd64, left edge of the 16x16-character text box (pixels).
- Y_POS, 11'd48, top edge of the text box (pixels).
- TEXT_COLOR, 12'hFFF, glyph foreground colour.
- HILITE_COLOR, 12'h00F, background colour of the highlighted row inside the box.

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- vcount_in  in  11  vertical counter
- hcount_in  in  11  horizontal counter
- vsync_in, hsync_in, vblnk_in, hblnk_in  in  1 each  timing strobes
- rgb_in  in  12  background pixel
- sel_row  in  4  menu cursor row, 0..15
- hilite_en  in  1  enables highlight
- char_xy  out  8  text ROM address {row, col}
- char_code  in  7  text ROM data, valid 1 clk after char_xy
- char_line  out  4  glyph line within cell; font ROM address = {char_code, char_line}
- char_pixels  in  8  font ROM data, MSB = leftmost pixel, valid 1 clk after {char_code, char_line}
- vcount_out, hcount_out  out  11  timing delayed 4 clk
- vsync_out, hsync_out, vblnk_out, hblnk_out  out  1  timing delayed 4 clk
- rgb_out  out  12  composited pixel, delayed 4 clk

Behaviour:
- Box: 128x256 px, 8x16 px cells.
  - in_box = hcount_in in [X_POS, X_POS+127] and vcount_in in [Y_POS, Y_POS+255] and neither blank active.
- Offsets: dx = hcount_in - X_POS, dy = vcount_in - Y_POS, 11-bit unsigned subtraction. They are used only when in_box, so wrap is irrelevant.
- Cell address: col = dx[6:3], row = dy[7:4], xoff = dx[2:0], line = dy[3:0].
- Pipeline, with inputs at cycle N:
  - N+1: char_xy registered = {row, col}. Timing, rgb, in_box, row, xoff and line are registered into stage 1.
  - N+2: text ROM delivers char_code. char_line is registered = line from stage 1, so it is aligned with char_code. Stage 2 holds timing, rgb, in_box, row and xoff.
  - N+3: font ROM delivers char_pixels. Stage 3 holds timing, rgb, in_box, row and xoff.
  - N+4: all *_out registered.
- Compositing at the output register:
  - Pixel is set when char_pixels[7 - xoff] = 1.
  - If not in_box: rgb_out = rgb.
  - Else if the pixel is set: rgb_out = TEXT_COLOR.
  - Else if hl_en_q and row == sel_q: rgb_out = HILITE_COLOR.
  - Else: rgb_out = rgb.
- Highlight latch:
  - sel_q and hl_en_q load sel_row and hilite_en on the cycle where vcount_in == 0 and hcount_in == 0.
  - They hold for the whole frame. A mid-frame change of sel_row has no visible effect until the next frame.
- Out-of-box cycles: char_xy and char_line keep their last values. The ROM outputs are don't-care there and are masked by in_box.
- Reset:
  - All pipeline registers, all *_out, char_xy, char_line, sel_q and hl_en_q are 0.
  - rgb_out = 0 for the first 4 clocks after reset release.
  - Reset mid-frame clears everything. The highlight stays off until the next vcount=0, hcount=0.
- Boundaries:
  - hcount_in = X_POS-1 gives not in_box.
  - X_POS+127 is the last in-box column.
  - Y_POS+255 gives row 15, line 15.

Decomposition:
- vga_pkg: add CHAR_W=8, CHAR_H=16, TXT_COLS=16, TXT_ROWS=16, plus the default colour constants.
- No sub-module. The 4-stage delay uses a generic delay line (existing "delay" module, WIDTH=38, CLK_DEL=3) for timing+rgb. in_box, row and xoff travel alongside in that line.

Test Plan:
- Reset asserted, then released on a free-running counter → all outputs 0 for 4 clk, then hcount_out and vcount_out track the inputs delayed by exactly 4.
- X_POS=64, Y_POS=48, hcount=64+8*3+2, vcount=48+16*2+5 → char_xy=8'h23 at N+1, char_line=4'd5 at N+2.
- Model ROMs return char_pixels=8'b0010_0000 with xoff=2 → rgb_out=12'hFFF at N+4. With xoff=3 → rgb_out=rgb_in delayed.
- sel_row=4'd2, hilite_en=1 latched at frame start; pixel in row 2 with glyph bit 0 → rgb_out=12'h00F. Same pixel in row 3 → rgb_in.
- Change sel_row 2→5 mid-frame → row 2 stays highlighted until vcount=0, then row 5.
- Pixel at hcount=63 or 192, or hblnk_in=1 inside the box → rgb_out = delayed rgb_in, regardless of char_pixels.
